// File: rtl/optical_byte_receiver.sv
// Slices ADC samples, recovers 8N1 frames at OSR samples per bit and queues bytes in a show-ahead FIFO.
// Latency: byte visible one cycle after the stop-bit sample. Backpressure via dout_ready; full FIFO drops and sets overflow. Option: OPT_RX_HYST_EN.
module optical_byte_receiver #(
    parameter int DATA_W     = 8,
    parameter int OSR        = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int HYST       = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               level,
    input  logic [DATA_W-1:0]               din,
    input  logic                            den,
    output logic [7:0]                      dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    output logic                            frame_err,
    output logic                            busy
);
    localparam int STOP_PT = OSR / 2 + 9 * OSR;
    localparam int SW      = $clog2(STOP_PT + 1);
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [SW-1:0] HALF = SW'(OSR / 2);
    localparam logic [SW-1:0] STEP = SW'(OSR);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    if (OSR < 4 || (OSR % 2) != 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || HYST < 0 || HYST >= 2**DATA_W) begin : g_param_check
        $error("optical_byte_receiver: illegal parameter set");
    end

    logic [1:0]    state;
    logic [SW-1:0] scnt;
    logic [SW-1:0] next_pt;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic          prev_bit;
    logic          line_bit;
    logic          hit;
    logic          push_req;
    logic          push_ok;
    logic          pop;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

`ifdef OPT_RX_HYST_EN
    logic [DATA_W:0]   hi_sum;
    logic [DATA_W-1:0] hi_thr;
    logic [DATA_W-1:0] lo_thr;

    // Thresholds saturate at the code range ends; inside the band the last decision is held.
    always_comb begin
        hi_sum = {1'b0, level} + (DATA_W + 1)'(HYST);
        hi_thr = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
        lo_thr = (level < DATA_W'(HYST)) ? '0 : level - DATA_W'(HYST);
        if (din > hi_thr) begin
            line_bit = 1'b1;
        end else if (din < lo_thr) begin
            line_bit = 1'b0;
        end else begin
            line_bit = prev_bit;
        end
    end
`else
    assign line_bit = (din > level);
`endif

    // next_pt tracks the next mid-bit sample index so one comparator serves every bit.
    assign hit = (scnt == next_pt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            scnt     <= '0;
            next_pt  <= HALF;
            bcnt     <= '0;
            shreg    <= '0;
            prev_bit <= 1'b1;
        end else if (den) begin
            prev_bit <= line_bit;
            case (state)
                S_IDLE: begin
                    if (prev_bit && !line_bit) begin
                        state   <= S_START;
                        scnt    <= SW'(1);
                        next_pt <= HALF;
                        bcnt    <= '0;
                    end
                end
                S_START: begin
                    scnt <= scnt + 1'b1;
                    if (hit) begin
                        if (line_bit) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            next_pt <= next_pt + STEP;
                        end
                    end
                end
                S_DATA: begin
                    scnt <= scnt + 1'b1;
                    if (hit) begin
                        shreg   <= {line_bit, shreg[7:1]};
                        next_pt <= next_pt + STEP;
                        bcnt    <= bcnt + 1'b1;
                        if (bcnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                end
                default: begin
                    scnt <= scnt + 1'b1;
                    if (hit) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign push_req  = !rst && den && (state == S_STOP) && hit && line_bit;
    assign frame_err = !rst && den && (state == S_STOP) && hit && !line_bit;
    assign busy      = (state != S_IDLE);

    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;
    assign push_ok    = push_req && ((count != CW'(FIFO_DEPTH)) || pop);
    assign dout       = dout_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_optical_byte_receiver.sv
// Directed bench for optical_byte_receiver: frame-level reference model plus hand-computed spot checks.
module tb_optical_byte_receiver;
    localparam int DATA_W     = 8;
    localparam int OSR        = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int HYST       = 4;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int STOP_OFF   = OSR / 2 + 9 * OSR;
    localparam int MAXV       = 2**DATA_W - 1;
    localparam logic [7:0] HI = 8'd200;
    localparam logic [7:0] LO = 8'd50;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] level;
    logic [DATA_W-1:0] din;
    logic              den;
    logic [7:0]        dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [CW-1:0]     fifo_count;
    logic              overflow;
    logic              frame_err;
    logic              busy;

    optical_byte_receiver #(
        .DATA_W(DATA_W), .OSR(OSR), .FIFO_DEPTH(FIFO_DEPTH), .HYST(HYST)
    ) dut (
        .clk(clk), .rst(rst), .level(level), .din(din), .den(den),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: line decisions are kept as a history indexed by sample number,
    // and a frame is decoded by looking up mid-bit positions relative to its start edge.
    bit         hist [0:32767];
    int         n_smp;
    int         start_idx;
    bit         m_prev;
    bit         m_ovf;
    logic [7:0] q [$];
    bit         chk_en = 1'b0;
    int         ferr_seen = 0;

    function automatic bit slice(input logic [7:0] d, input logic [7:0] l, input bit p);
`ifdef OPT_RX_HYST_EN
        int hi;
        int lo;
        hi = int'(l) + HYST;
        lo = int'(l) - HYST;
        if (hi > MAXV) hi = MAXV;
        if (lo < 0) lo = 0;
        if (int'(d) > hi) return 1'b1;
        if (int'(d) < lo) return 1'b0;
        return p;
`else
        return d > l;
`endif
    endfunction

    bit         mb;
    bit         mpop;
    bit         mpush;
    logic [7:0] mbyte;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf     = 1'b0;
            start_idx = -1;
            m_prev    = 1'b1;
            n_smp     = 0;
        end else begin
            mpop  = (q.size() > 0) && dout_ready;
            mpush = 1'b0;
            mbyte = 8'h00;
            if (den) begin
                mb = slice(din, level, m_prev);
                hist[n_smp] = mb;
                if (start_idx < 0) begin
                    if (m_prev && !mb) start_idx = n_smp;
                end else if ((n_smp - start_idx == OSR / 2) && mb) begin
                    start_idx = -1;
                end else if (n_smp - start_idx == STOP_OFF) begin
                    if (mb) begin
                        mpush = 1'b1;
                        for (int k = 0; k < 8; k++)
                            mbyte[k] = hist[start_idx + OSR / 2 + (k + 1) * OSR];
                    end
                    start_idx = -1;
                end
                m_prev = mb;
                n_smp++;
            end
            if (mpop) void'(q.pop_front());
            if (mpush) begin
                if (q.size() < FIFO_DEPTH) q.push_back(mbyte);
                else m_ovf = 1'b1;
            end
        end
    end

    bit exp_fe;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_fe = !rst && den && (start_idx >= 0) && (n_smp - start_idx == STOP_OFF)
                     && !slice(din, level, m_prev);
            check("frame_err", frame_err, exp_fe);
            if (frame_err) ferr_seen++;
            check("dout_valid", dout_valid, q.size() != 0);
            check("dout", dout, (q.size() != 0) ? q[0] : 8'h00);
            check("fifo_count", fifo_count, q.size());
            check("overflow", overflow, m_ovf);
            check("busy", busy, start_idx >= 0);
        end
    end

    int gap = 0;

    task automatic put(input logic [7:0] v);
        repeat (gap) begin
            den = 1'b0;
            din = v;
            @(posedge clk); #1;
        end
        din = v;
        den = 1'b1;
        @(posedge clk); #1;
        den = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) put(HI);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_hi, input bit pop_at_stop, input int max_s);
        int  b;
        bit  lv;
        for (int i = 0; i < 10 * OSR && i < max_s; i++) begin
            b = i / OSR;
            if (b == 0) lv = 1'b0;
            else if (b <= 8) lv = d[b-1];
            else lv = stop_hi;
            if (pop_at_stop) dout_ready = (i == STOP_OFF);
            put(lv ? HI : LO);
        end
        if (pop_at_stop) dout_ready = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        dout_ready = 1'b1;
        while (dout_valid && t < 40) begin
            put(HI);
            t++;
        end
        dout_ready = 1'b0;
        check("drain_empty", dout_valid, 0);
    endtask

    logic [7:0] exp_q [$];
    int         fe0;

    initial begin
        rst = 1'b1; den = 1'b0; din = HI; level = 8'd128; dout_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk_en = 1'b1;
        rst = 1'b0;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        idle(4);

        // Clean 0xA5 frame, sliced at the stop-bit middle sample
        send_frame(8'hA5, 1'b1, 1'b0, STOP_OFF);
        check("a5_before_stop", dout_valid, 0);
        put(HI);
        check("a5_latency_valid", dout_valid, 1);
        check("a5_dout", dout, 8'hA5);
        idle(3 + 2 * OSR);
        check("a5_count", fifo_count, 1);
        drain();

        // Short low glitch aborts at the start-bit check
        fe0 = ferr_seen;
        put(LO); put(LO); put(LO);
        idle(2 * OSR);
        check("glitch_busy", busy, 0);
        check("glitch_count", fifo_count, 0);
        check("glitch_no_ferr", ferr_seen - fe0, 0);

        // Stop bit low, line then held low
        fe0 = ferr_seen;
        send_frame(8'h3C, 1'b0, 1'b0, 10 * OSR);
        repeat (30) put(LO);
        idle(20);
        check("ferr_once", ferr_seen - fe0, 1);
        check("ferr_count", fifo_count, 0);

        // 17 frames with no consumer: 16 stored, one dropped
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 10 * OSR);
            idle(2);
        end
        check("full_count", fifo_count, 16);
        check("full_overflow", overflow, 1);

        // Push into a full FIFO while popping on the same cycle
        send_frame(8'h77, 1'b1, 1'b1, 10 * OSR);
        idle(2);
        check("fullpp_count", fifo_count, 16);
        exp_q.delete();
        for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h77);
        dout_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check("order_valid", dout_valid, 1);
            check("order_byte", dout, exp_q[j]);
            put(HI);
        end
        dout_ready = 1'b0;
        check("order_empty", dout_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Reset mid data bit with sparse den
        gap = 2;
        send_frame(8'h99, 1'b1, 1'b0, 3 * OSR + 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_valid", dout_valid, 0);
        check("mrst_dout", dout, 0);
        check("mrst_count", fifo_count, 0);
        check("mrst_overflow", overflow, 0);
        check("mrst_ferr", frame_err, 0);
        idle(4);
        send_frame(8'h5A, 1'b1, 1'b0, 10 * OSR);
        idle(4);
        check("sparse_5a", dout, 8'h5A);
        check("sparse_count", fifo_count, 1);
        gap = 0;
        drain();

        // Sample equal to level
        idle(2);
        put(8'd128);
`ifdef OPT_RX_HYST_EN
        check("tie_busy", busy, 0);
`else
        check("tie_busy", busy, 1);
`endif
        idle(2 * OSR);

`ifdef OPT_RX_HYST_EN
        for (int i = 0; i < 30; i++) put(8'(126 + (i % 5)));
        check("hyst_busy", busy, 0);
        idle(4);
        check("hyst_count", fifo_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end
endmodule

// File: doc/optical_byte_receiver.md
Name: optical_byte_receiver

Overview:
Parametrised successor to the current AD-sample receiver path. It slices a stream of ADC samples against a programmable level, recovers UART-style frames (start, 8 data bits LSB first, stop) at a configurable oversampling ratio, and buffers the recovered bytes in an internal FIFO. Output is a valid/ready byte stream for the controller/UART transmit path. Sits between ad_driver and controller.

Parameters:
DATA_W, 8, ADC sample and level width
OSR, 8, ADC samples per line bit; even, >= 4
FIFO_DEPTH, 16, byte FIFO depth; power of 2, >= 2
HYST, 4, hysteresis half-width in LSBs (used only with OPT_RX_HYST_EN)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
level  in  DATA_W  slicing threshold, unsigned, sampled every den cycle
din  in  DATA_W  ADC sample, unsigned
den  in  1  din valid strobe; one sample per asserted cycle
dout  out  8  FIFO head byte (show-ahead)
dout_valid  out  1  FIFO non-empty
dout_ready  in  1  consumer accepts dout this cycle
fifo_count  out  clog2(FIFO_DEPTH+1)  bytes stored
overflow  out  1  sticky: a byte was dropped because FIFO was full
frame_err  out  1  one-cycle pulse: stop bit sampled low
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=1 at a clock edge): FSM=IDLE, FIFO emptied, fifo_count=0, dout_valid=0, dout=0, overflow=0, frame_err=0, busy=0, prev_bit=1. A reset mid-frame discards the partial byte.
- All FSM and slicer state advances only on cycles with den=1; den=0 cycles hold state (FIFO pop still operates).
- Slicer (combinational on current sample): bit = (din > level), unsigned compare; din == level gives 0.
- prev_bit register updates to bit on each den cycle.
- Sample counter scnt is reset to 0 on the start-edge sample; it increments each den cycle while busy.
- IDLE: prev_bit=1 and bit=0 -> START, scnt=0.
- START: at scnt==OSR/2: bit=0 -> DATA; bit=1 -> IDLE (glitch, no error).
- DATA: bit k (k=0..7) sampled at scnt==OSR/2+(k+1)*OSR and shifted in LSB first. After k=7 -> STOP.
- STOP: at scnt==OSR/2+9*OSR:
  - bit=1 -> push byte, then IDLE.
  - bit=0 -> frame_err=1 for that cycle, byte discarded, IDLE.
  - A line held low after a frame error does not retrigger; IDLE needs a 1->0 edge.
- Latency: a pushed byte appears on dout/dout_valid the cycle after the stop-bit den cycle, if the FIFO was empty.
- FIFO:
  - Pop when dout_valid && dout_ready.
  - Push is accepted if fifo_count<FIFO_DEPTH, or if a pop occurs in the same cycle (full + simultaneous pop/push: count unchanged, order kept).
  - Push rejected when full with no pop: byte dropped, overflow set; it clears only on rst.
  - Pop on empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count is exact every cycle.
- dout is stable while dout_valid=1 and dout_ready=0.

Optional Feature:
OPT_RX_HYST_EN.
- Defined: bit = 1 when din > level+HYST; bit = 0 when din < level-HYST; otherwise bit = prev_bit. Thresholds saturate at 0 and 2^DATA_W-1.
- Undefined: plain compare as above; HYST is unused.

Test Plan:
- OSR=8, level=128, den every cycle. Frame 0xA5 (high=200, low=50, 8 samples/bit, idle high before and after) -> single push, dout=0xA5, dout_valid one cycle after the stop-mid sample, frame_err=0.
- Low pulse of 3 samples, then high -> returns to IDLE at START check, no push, no frame_err, busy falls.
- Frame 0x3C with stop bit low -> frame_err pulse exactly at stop-mid sample, fifo_count stays 0; line held low afterwards produces no further frames.
- dout_ready=0, send 17 frames 0x00..0x10 -> fifo_count=16, overflow=1. Then drain -> 0x00..0x0F in order and 0x10 absent. overflow stays 1 until rst.
- FIFO full with dout_ready=1 on the same cycle as a stop-bit push -> pop and push both occur, fifo_count stays 16, new byte appears last.
- rst asserted mid-data-bit of a frame, den toggling 1-of-3 cycles -> all outputs zero next cycle. A subsequent clean 0x5A frame is received correctly. With OPT_RX_HYST_EN, HYST=4: samples at 126..130 chatter keep bit unchanged.
